// File: rtl/loader_pkg.sv
// Shared types for the UART program loader.
// Loader and receiver state encodings plus the ack byte.
package loader_pkg;

    typedef enum logic [1:0] {
        S_LEN,
        S_DATA,
        S_ACK,
        S_DONE
    } load_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] ACK_BYTE = 8'hAA;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, start glitch reject,
// mid-bit sampling. Outputs are single-cycle pulses.
module uart_rx_core
    import loader_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       stop_err,
    output logic       start_ok
);

    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int CNT_W   = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);

    rx_state_e        state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RX_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sync1_d    = rxd;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        start_ok   = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    // Line back high at mid-start means a glitch.
                    if (sync2_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d  = RX_DATA;
                        bit_d    = '0;
                        start_ok = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    sh_d  = {sync2_q, sh_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d      = '0;
                    byte_valid = 1'b1;
                    stop_err   = !sync2_q;
                    state_d    = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte = sh_q;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives word count and program words over UART,
// writes them to instruction BRAM, then sends an ack byte.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int INST_SIZE        = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rxd,
    output logic                 txd,
    output logic                 load_we,
    output logic [INST_SIZE-1:0] load_addr,
    output logic [31:0]          load_data,
    output logic                 busy,
    output logic                 done,
    output logic                 frame_err
);

    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int CNT_W   = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       stop_err;
    logic       start_ok;

    uart_rx_core #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_rx (
        .clk       (clk),
        .rstn      (rstn),
        .rxd       (rxd),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .stop_err  (stop_err),
        .start_ok  (start_ok)
    );

    load_state_e          state_q, state_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [31:0]          n_q, n_d;
    logic [31:0]          word_q, word_d;
    logic [31:0]          k_q, k_d;
    logic                 we_q, we_d;
    logic [INST_SIZE-1:0] addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic [9:0]           tx_sh_q, tx_sh_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic                 start_ack;
    logic                 rx_active;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_LEN;
            byte_cnt_q <= '0;
            n_q        <= '0;
            word_q     <= '0;
            k_q        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            tx_sh_q    <= '1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            n_q        <= n_d;
            word_q     <= word_d;
            k_q        <= k_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    assign rx_active = (state_q == S_LEN) || (state_q == S_DATA);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        n_d        = n_q;
        word_d     = word_q;
        k_d        = k_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        ferr_d     = ferr_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_cnt_d   = tx_cnt_q;
        start_ack  = 1'b0;

        if (start_ok && rx_active) busy_d = 1'b1;
        if (byte_valid && stop_err && rx_active) ferr_d = 1'b1;

        unique case (state_q)
            S_LEN: begin
                if (byte_valid) begin
                    n_d        = {rx_byte, n_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        k_d = '0;
                        if (n_d == 32'd0) start_ack = 1'b1;
                        else              state_d   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (byte_valid) begin
                    word_d     = {rx_byte, word_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        // Words past BRAM capacity are drained, not written.
                        if (k_q[31:INST_SIZE] == '0) begin
                            we_d   = 1'b1;
                            addr_d = k_q[INST_SIZE-1:0];
                            data_d = word_d;
                        end
                        k_d = k_q + 32'd1;
                        if (k_d == n_q) start_ack = 1'b1;
                    end
                end
            end
            S_ACK: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                    tx_bit_d = tx_bit_q + 1'b1;
                    if (tx_bit_q == 4'd9) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
            end
            default: state_d = S_LEN;
        endcase

        if (start_ack) begin
            state_d  = S_ACK;
            tx_sh_d  = {1'b1, ACK_BYTE, 1'b0};
            tx_bit_d = '0;
            tx_cnt_d = '0;
        end
    end

    assign txd       = tx_sh_q[0];
    assign load_we   = we_q;
    assign load_addr = addr_q;
    assign load_data = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader with write and ack
// scoreboards fed by the stimulus and drained by monitors.
module tb_uart_program_loader;

    localparam int H    = 4;
    localparam int BIT  = 2 * H;
    localparam int ISZ  = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           rxd = 1'b1;
    logic           txd;
    logic           load_we;
    logic [ISZ-1:0] load_addr;
    logic [31:0]    load_data;
    logic           busy;
    logic           done;
    logic           frame_err;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    wr_t exp_q[$];
    logic [7:0] tx_got[$];
    logic [7:0] tx_b;

    uart_program_loader #(
        .CLK_PER_HALF_BIT(H),
        .INST_SIZE(ISZ)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rxd      (rxd),
        .txd      (txd),
        .load_we  (load_we),
        .load_addr(load_addr),
        .load_data(load_data),
        .busy     (busy),
        .done     (done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && load_we) begin
            wr_t e;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("we_addr", 32'(load_addr), e.a);
                check("we_data", load_data, e.d);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rstn && txd === 1'b0) begin
                repeat (H - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    tx_b = {txd, tx_b[7:1]};
                end
                repeat (BIT) @(negedge clk);
                check("tx_stop", 32'(txd), 32'd1);
                tx_got.push_back(tx_b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clk);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = stop;
        repeat (BIT) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        rxd  = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.delete();
        tx_got.delete();
        wr_cnt = 0;
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_ack(input string tag);
        logic [7:0] b;
        check({tag, "_ack_count"}, 32'(tx_got.size()), 32'd1);
        if (tx_got.size() != 0) begin
            b = tx_got.pop_front();
            check({tag, "_ack_byte"}, 32'(b), 32'hAA);
        end
        check({tag, "_wr_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_we", 32'(load_we), 32'd0);
        check("rst_addr", 32'(load_addr), 32'd0);
        check("rst_data", load_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // two-word load
        send_word(32'd2);
        check("t1_busy", 32'(busy), 32'd1);
        push_wr(0, 32'h12345678);
        send_word(32'h12345678);
        push_wr(1, 32'hDEADBEEF);
        send_word(32'hDEADBEEF);
        wait_done("t1");
        check_ack("t1");
        check("t1_wr_cnt", 32'(wr_cnt), 32'd2);

        // bytes after done are ignored
        send_word(32'h11223344);
        repeat (20) @(negedge clk);
        check("t6_no_tx", 32'(tx_got.size()), 32'd0);
        check("t6_done", 32'(done), 32'd1);
        check("t6_txd", 32'(txd), 32'd1);
        check("t6_wr_cnt", 32'(wr_cnt), 32'd2);

        // zero-length program
        do_reset();
        send_word(32'd0);
        wait_done("t2");
        check_ack("t2");
        check("t2_wr_cnt", 32'(wr_cnt), 32'd0);

        // more words than BRAM capacity
        do_reset();
        send_word(32'd18);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) push_wr(i, 32'hA5000000 + 32'(i * 3));
            send_word(32'hA5000000 + 32'(i * 3));
        end
        check("t3_not_done", 32'(done), 32'd0);
        check("t3_wr16", 32'(wr_cnt), 32'd16);
        send_word(32'hFFFF0011);
        wait_done("t3");
        check_ack("t3");
        check("t3_wr_cnt", 32'(wr_cnt), 32'd16);

        // glitch, then a frame-errored count byte
        do_reset();
        @(negedge clk);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        check("t4_glitch_busy", 32'(busy), 32'd0);
        check("t4_glitch_ferr", 32'(frame_err), 32'd0);
        send_byte(8'h01, 1'b0);
        check("t4_ferr", 32'(frame_err), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        push_wr(0, 32'hCAFEF00D);
        send_word(32'hCAFEF00D);
        wait_done("t4");
        check_ack("t4");
        check("t4_ferr_sticky", 32'(frame_err), 32'd1);

        // reset in the middle of a word
        do_reset();
        send_word(32'd2);
        push_wr(0, 32'h55AA33CC);
        send_word(32'h55AA33CC);
        send_byte(8'h77);
        send_byte(8'h66);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("t5_rst_data", load_data, 32'd0);
        check("t5_rst_addr", 32'(load_addr), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_txd", 32'(txd), 32'd1);
        check("t5_rst_we", 32'(load_we), 32'd0);
        repeat (2) @(negedge clk);
        wr_cnt = 0;
        exp_q.delete();
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        send_word(32'd1);
        push_wr(0, 32'h0BADF00D);
        send_word(32'h0BADF00D);
        wait_done("t5");
        check_ack("t5");
        check("t5_wr_cnt", 32'(wr_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
